// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
// Shared types for the Wishbone B3 RAM slave:
//   cti_t    - cycle type indicator codes
//   bte_t    - burst type extension codes
//   state_t  - slave FSM states
//   burst_next() - next word index of a burst for a given burst type
// -----------------------------------------------------------------------------
package wishbone_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CLASSIC = 2'b01,
        ST_BURST   = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    // Wrap bursts keep the upper index bits and count the low bits modulo N.
    // Linear bursts simply increment; the caller truncates to the RAM depth,
    // which gives the modulo-MEM_WORDS wrap.
    function automatic logic [31:0] burst_next(input logic [31:0] idx, input bte_t bte);
        logic [31:0] inc;
        inc = idx + 32'd1;
        case (bte)
            BTE_LINEAR: burst_next = inc;
            BTE_WRAP4:  burst_next = {idx[31:2], inc[1:0]};
            BTE_WRAP8:  burst_next = {idx[31:3], inc[2:0]};
            BTE_WRAP16: burst_next = {idx[31:4], inc[3:0]};
            default:    burst_next = inc;
        endcase
    endfunction

endpackage

// File: rtl/wb_ram_array.sv
// -----------------------------------------------------------------------------
// wb_ram_array
// Single-port synchronous RAM with per-byte write enables. Read-first: the
// registered read data shows the word as it was before a same-cycle write.
// Contents are never reset; only the read register is.
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset (read register only)
//   addr   in   word address
//   be     in   byte write enables
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module wb_ram_array #(
    parameter int WORDS      = 1024,
    parameter int IDX_W      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_r [WORDS];

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (be[b]) begin
                mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/wishbone_b3_ram_slave.sv
// -----------------------------------------------------------------------------
// wishbone_b3_ram_slave
// Wishbone B3 slave exposing an on-chip RAM window at BASE_ADDRESS. Supports
// classic cycles (one ack per two cycles) and incrementing bursts (linear,
// wrap-4/8/16) with zero-wait beats. Out-of-range requests end with err.
// Ports:
//   clock    in   bus clock
//   reset    in   async active-low reset
//   cyc,stb  in   master cycle / strobe
//   we       in   write enable
//   adr      in   byte address (bits [1:0] ignored)
//   sel      in   byte lane selects
//   datMosi  in   write data
//   cti,bte  in   cycle type / burst type
//   datMiso  out  read data
//   ack,err  out  normal / error termination
//   rty      out  retry, tied low
// -----------------------------------------------------------------------------
module wishbone_b3_ram_slave
    import wishbone_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter int          MEM_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cyc,
    input  logic                     stb,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH/8-1:0]  sel,
    input  logic [DATA_WIDTH-1:0]    datMosi,
    input  logic [2:0]               cti,
    input  logic [1:0]               bte,
    output logic [DATA_WIDTH-1:0]    datMiso,
    output logic                     ack,
    output logic                     err,
    output logic                     rty
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int AW1   = ADDRESS_WIDTH + 1;
    // One extra bit so BASE + window size cannot overflow the compare.
    localparam logic [AW1-1:0] BASE_EXT  = AW1'(BASE_ADDRESS);
    localparam logic [AW1-1:0] LIMIT_EXT = BASE_EXT + AW1'(4 * MEM_WORDS);

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   ptr_r, ptr_n;
    logic [IDX_W-1:0]   req_idx_s, ptr_next_s, mem_addr_s;
    logic [DATA_WIDTH/8-1:0] mem_be_s;
    logic [AW1-1:0]     adr_ext_s, off_s;
    logic               in_range_s, cyc_stb_s, ack_s, err_s;

    assign adr_ext_s  = {1'b0, adr};
    assign off_s      = adr_ext_s - BASE_EXT;
    assign in_range_s = (adr_ext_s >= BASE_EXT) && (adr_ext_s < LIMIT_EXT);
    assign req_idx_s  = IDX_W'(off_s >> 2);
    assign cyc_stb_s  = cyc & stb;
    assign ptr_next_s = IDX_W'(burst_next(32'(ptr_r), bte_t'(bte)));

    // State and burst pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
        end
    end

    // Next-state, RAM control and termination decode.
    always_comb begin
        state_n    = state_r;
        ptr_n      = ptr_r;
        mem_addr_s = ptr_r;
        mem_be_s   = {(DATA_WIDTH/8){1'b0}};
        ack_s      = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Read the requested word now so it is ready in the next cycle.
                mem_addr_s = req_idx_s;
                if (cyc_stb_s) begin
                    ptr_n = req_idx_s;
                    if (!in_range_s) begin
                        state_n = ST_ERROR;
                    end else if (cti == CTI_INCR) begin
                        state_n = ST_BURST;
                    end else begin
                        state_n = ST_CLASSIC;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CLASSIC: begin
                if (cyc_stb_s) begin
                    ack_s = 1'b1;
                    if (we) begin
                        mem_be_s = sel;
                    end else begin
                        mem_be_s = {(DATA_WIDTH/8){1'b0}};
                    end
                end else begin
                    ack_s = 1'b0;
                end
                state_n = ST_IDLE;
            end
            ST_BURST: begin
                // The pointer is kept modulo MEM_WORDS and wraps stay inside
                // an aligned block, so a beat never leaves the window and a
                // burst therefore never ends with err.
                if (!cyc) begin
                    state_n = ST_IDLE;
                end else if (stb) begin
                    ack_s = 1'b1;
                    ptr_n = ptr_next_s;
                    if (we) begin
                        mem_be_s = sel;
                    end else begin
                        // Pre-read the following word for a zero-wait next beat.
                        mem_addr_s = ptr_next_s;
                    end
                    if (cti == CTI_EOB) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_BURST;
                    end
                end else begin
                    state_n = ST_BURST;
                end
            end
            ST_ERROR: begin
                err_s   = cyc_stb_s;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    wb_ram_array #(
        .WORDS      (MEM_WORDS),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clock),
        .rst_n (reset),
        .addr  (mem_addr_s),
        .be    (mem_be_s),
        .wdata (datMosi),
        .rdata (datMiso)
    );

    assign ack = ack_s;
    assign err = err_s;
    assign rty = 1'b0;

endmodule

// File: doc/wishbone_b3_ram_slave.md
WISHBONE_B3_RAM_SLAVE -- requirements
Module: wishbone_b3_ram_slave

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: byte address width of adr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; fixed at 32, so sel is 4 bits.
REQ-003 SHALL have parameter MEM_WORDS, default 1024: memory depth in words; must be a power of 2.
REQ-004 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000: first byte address decoded.
REQ-005 SHALL have one clock and asynchronous active-low reset, per the ports below.
REQ-006 clock  in  1  bus clock; all state on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 cyc  in  1  master cycle valid.
REQ-009 stb  in  1  master strobe.
REQ-010 we  in  1  write enable.
REQ-011 adr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored.
REQ-012 sel  in  4  byte lane selects.
REQ-013 datMosi  in  32  write data.
REQ-014 cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other codes treated as classic.
REQ-015 bte  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-016 datMiso  out  32  read data.
REQ-017 ack  out  1  normal termination.
REQ-018 err  out  1  error termination.
REQ-019 rty  out  1  retry; SHALL be constant 0.

Function
REQ-020 Range check: address in range iff BASE_ADDRESS <= adr < BASE_ADDRESS + 4*MEM_WORDS.
REQ-021 Word index: (adr - BASE_ADDRESS) >> 2.
REQ-022 FSM states: IDLE, CLASSIC, BURST, ERROR.
REQ-023 IDLE, on cyc & stb:
- out of range -> ERROR.
- in range and cti=010 -> BURST.
- otherwise -> CLASSIC.
REQ-024 Memory SHALL have synchronous read: it is read at the request word in the request cycle.
REQ-025 CLASSIC: ack=1 for exactly one cycle (request cycle + 1), datMiso = word; then return to IDLE.
REQ-026 Classic back-to-back requests therefore complete at most one per 2 cycles.
REQ-027 Writes SHALL update only byte lanes with sel=1, in the ack cycle, using that cycle's datMosi.
REQ-028 Read-after-write SHALL return the new data.
REQ-029 BURST: ack = cyc & stb, combinational from the registered state.
REQ-030 BURST: each acked beat advances the internal word pointer per bte; the memory pre-reads the next word so the next beat has zero wait.
REQ-031 Wrap-N bursts SHALL keep the upper index bits fixed and increment the low log2(N) index bits modulo N.
REQ-032 Linear bursts SHALL wrap modulo MEM_WORDS.
REQ-033 BURST: stb low with cyc high (master wait) SHALL hold the pointer; ack=0 that cycle.
REQ-034 BURST: an acked beat with cti=111 is the last beat; next state IDLE.
REQ-035 BURST: a beat whose pointer leaves the range SHALL terminate with err instead of ack; next state IDLE.
REQ-036 ERROR: err=1 for one cycle, no memory write; then IDLE.
REQ-037 cyc low in any state SHALL force IDLE next cycle and gate ack/err low combinationally; any pending write is dropped.
REQ-038 ack and err SHALL never be asserted together.
REQ-039 ack/err SHALL never assert without cyc & stb.

Reset
REQ-040 Reset low SHALL immediately force: FSM IDLE; ack=0, err=0, rty=0; datMiso=0; pointer=0.
REQ-041 Memory contents SHALL NOT be reset.
REQ-042 Reset mid-burst SHALL abort without writing; the first request after release is treated as new.

Structure
REQ-043 Package wishbone_pkg SHALL hold the cti_t and bte_t enums and the state enum.
REQ-044 Sub-module wb_ram_array SHALL provide the single-port synchronous RAM with byte enables.

Verification
REQ-045 Classic read: reset; preload word 5 = 32'hDEAD_BEEF; read adr=0x14 -> ack exactly 1 cycle later, datMiso=32'hDEAD_BEEF, ack low after.
REQ-046 Byte write: write 32'h1122_3344 to 0x14 with sel=4'b0101 -> read returns 32'hDE22_BE44.
REQ-047 Wrap-4 read burst: adr=0x18, bte=01, stb held, cti=111 on beat 4 -> acks on 4 consecutive cycles for words 6,7,4,5; then IDLE.
REQ-048 Master wait mid-burst: stb dropped for 2 cycles after beat 2 -> ack low for exactly those 2 cycles; beats 3-4 return the correct words.
REQ-049 Out-of-range: adr = BASE_ADDRESS + 4*MEM_WORDS, write -> err for 1 cycle, ack=0, memory unchanged.
REQ-050 Reset mid-burst: reset asserted during beat 2 of a write burst -> ack/err low immediately; beat-2 word not written.
